// File: rtl/obj_line_walker.sv
// Walks one screen row of a sprite, emitting per-column texel coordinates
// (mosaic quantised in screen space, then flipped) over a valid/ready stream.
module obj_line_walker #(
    parameter int COORD_W = 6,
    parameter int SIZE_W  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [SIZE_W-1:0]  hsize,
    input  logic [SIZE_W-1:0]  vsize,
    input  logic [COORD_W-1:0] row,
    input  logic               hflip,
    input  logic               vflip,
    input  logic               mosaic_en,
    input  logic [3:0]         mosaic_h,
    input  logic [3:0]         mosaic_v,
    output logic               busy,
    output logic               valid,
    input  logic               ready,
    output logic [COORD_W-1:0] tex_x,
    output logic [COORD_W-1:0] tex_y,
    output logic [COORD_W-1:0] scr_x,
    output logic               last
);

    typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;

    state_t             state_q, state_d;
    logic [SIZE_W-1:0]  hsize_q, hsize_d, vsize_q, vsize_d;
    logic [COORD_W-1:0] row_q, row_d, rem_q, rem_d;
    logic [COORD_W-1:0] col_q, col_d, qcol_q, qcol_d;
    logic [3:0]         mcnt_q, mcnt_d, mosaic_h_q, mosaic_h_d, mosaic_v_q, mosaic_v_d;
    logic               hflip_q, hflip_d, vflip_q, vflip_d, mosaic_en_q, mosaic_en_d;
    logic               valid_q, valid_d, last_q, last_d;
    logic [COORD_W-1:0] tex_x_q, tex_x_d, tex_y_q, tex_y_d, scr_x_q, scr_x_d;
    logic [COORD_W-1:0] col_n, qcol_n, qrow_n;

    // Subtraction is done at SIZE_W so s-1 is representable when s == 2^COORD_W.
    function automatic logic [COORD_W-1:0] flip(input logic [COORD_W-1:0] v,
                                                 input logic [SIZE_W-1:0]  s,
                                                 input logic               f);
        logic [SIZE_W-1:0] d;
        d = s - SIZE_W'(1) - SIZE_W'(v);
        flip = f ? d[COORD_W-1:0] : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        hsize_d     = hsize_q;
        vsize_d     = vsize_q;
        row_d       = row_q;
        rem_d       = rem_q;
        col_d       = col_q;
        qcol_d      = qcol_q;
        mcnt_d      = mcnt_q;
        mosaic_h_d  = mosaic_h_q;
        mosaic_v_d  = mosaic_v_q;
        hflip_d     = hflip_q;
        vflip_d     = vflip_q;
        mosaic_en_d = mosaic_en_q;
        valid_d     = valid_q;
        last_d      = last_q;
        tex_x_d     = tex_x_q;
        tex_y_d     = tex_y_q;
        scr_x_d     = scr_x_q;
        col_n       = col_q + COORD_W'(1);
        qcol_n      = qcol_q;
        qrow_n      = mosaic_en_q ? (row_q - rem_q) : row_q;

        case (state_q)
            IDLE: begin
                if (start && hsize != '0) begin
                    hsize_d     = hsize;
                    vsize_d     = vsize;
                    row_d       = row;
                    hflip_d     = hflip;
                    vflip_d     = vflip;
                    mosaic_en_d = mosaic_en;
                    mosaic_h_d  = mosaic_h;
                    mosaic_v_d  = mosaic_v;
                    rem_d       = row;
                    col_d       = '0;
                    mcnt_d      = '0;
                    qcol_d      = '0;
                    state_d     = PREP;
                end
            end
            PREP: begin
                // rem ends as row mod (mosaic_v+1), one block per cycle
                if (mosaic_en_q && SIZE_W'(rem_q) > SIZE_W'(mosaic_v_q)) begin
                    rem_d = rem_q - COORD_W'(mosaic_v_q) - COORD_W'(1);
                end else begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    tex_x_d = flip(COORD_W'(0), hsize_q, hflip_q);
                    tex_y_d = flip(qrow_n, vsize_q, vflip_q);
                    scr_x_d = '0;
                    last_d  = (hsize_q == SIZE_W'(1));
                end
            end
            RUN: begin
                if (ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        if (!mosaic_en_q || mcnt_q == mosaic_h_q) begin
                            mcnt_d = '0;
                            qcol_n = col_n;
                        end else begin
                            mcnt_d = mcnt_q + 4'd1;
                        end
                        col_d   = col_n;
                        qcol_d  = qcol_n;
                        tex_x_d = flip(qcol_n, hsize_q, hflip_q);
                        scr_x_d = col_n;
                        last_d  = (SIZE_W'(col_n) == hsize_q - SIZE_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hsize_q     <= '0;
            vsize_q     <= '0;
            row_q       <= '0;
            rem_q       <= '0;
            col_q       <= '0;
            qcol_q      <= '0;
            mcnt_q      <= '0;
            mosaic_h_q  <= '0;
            mosaic_v_q  <= '0;
            hflip_q     <= 1'b0;
            vflip_q     <= 1'b0;
            mosaic_en_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            tex_x_q     <= '0;
            tex_y_q     <= '0;
            scr_x_q     <= '0;
        end else begin
            state_q     <= state_d;
            hsize_q     <= hsize_d;
            vsize_q     <= vsize_d;
            row_q       <= row_d;
            rem_q       <= rem_d;
            col_q       <= col_d;
            qcol_q      <= qcol_d;
            mcnt_q      <= mcnt_d;
            mosaic_h_q  <= mosaic_h_d;
            mosaic_v_q  <= mosaic_v_d;
            hflip_q     <= hflip_d;
            vflip_q     <= vflip_d;
            mosaic_en_q <= mosaic_en_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            tex_x_q     <= tex_x_d;
            tex_y_q     <= tex_y_d;
            scr_x_q     <= scr_x_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign valid = valid_q;
    assign last  = last_q;
    assign tex_x = tex_x_q;
    assign tex_y = tex_y_q;
    assign scr_x = scr_x_q;

endmodule
